// File: rtl/score_display_driver_pkg.sv
// display_pkg: shared segment patterns, FSM states and sizing helpers for the score display driver
package display_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = '0;
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1110111, 7'b0010010, 7'b1011101, 7'b1011011, 7'b0111010,
        7'b1101011, 7'b1101111, 7'b1010010, 7'b1111111, 7'b1111010
    };
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic longint max_decimal(input int digits);
        longint r = 1;
        for (int i = 0; i < digits; i++) r = r * 10;
        return r - 1;
    endfunction
endpackage

// File: rtl/score_display_driver_if.sv
// score_display_driver_if: load/busy/valid handshake and result bus of the display driver
interface score_display_driver_if
    import display_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) ();
    logic [BIN_W-1:0]        value;
    logic                    load;
    logic                    blank_lz;
    logic                    busy;
    logic                    valid;
    logic                    overflow;
    logic [4*DIGITS-1:0]     bcd_out;
    logic [SEG_W*DIGITS-1:0] seg_out;
    modport master (output value, load, blank_lz, input busy, valid, overflow, bcd_out, seg_out);
    modport slave  (input value, load, blank_lz, output busy, valid, overflow, bcd_out, seg_out);
endinterface

// File: rtl/score_display_driver_encoder.sv
// seg7_digit_encoder: one BCD digit to the 7-bit segment pattern, with forced blanking
module seg7_digit_encoder
    import display_pkg::*;
(
    input  logic [3:0]       bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);
    assign seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd];
endmodule

// File: rtl/score_display_driver.sv
// score_display_driver: saturating double-dabble binary to BCD/segment converter, one shift per clock
module score_display_driver
    import display_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input logic Clk,
    input logic Reset,
    score_display_driver_if.slave bus
);
    localparam int SW = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam longint MAXD = max_decimal(DIGITS);
    // saturation only exists when the input range can exceed the display range
    localparam bit SAT_EN = MAXD < ((longint'(1) << BIN_W) - 1);
    localparam logic [BIN_W:0] MAX_BIN = SAT_EN ? (BIN_W+1)'(MAXD) : '0;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt;
    logic [SW-1:0]           scr, adj;
    logic                    lz, ovf, ovf_in, valid_q, ovf_q;
    logic [BIN_W-1:0]        cap;
    logic [4*DIGITS-1:0]     bcd, bcd_q;
    logic [SEG_W*DIGITS-1:0] seg_n, seg_q;
    logic [DIGITS-1:0]       hi_nz;

    assign ovf_in = SAT_EN && ({1'b0, bus.value} > MAX_BIN);
    assign cap    = ovf_in ? MAX_BIN[BIN_W-1:0] : bus.value;
    assign bcd    = scr[SW-1:BIN_W];

    always_comb begin
        adj = scr;
        for (int i = 0; i < DIGITS; i++)
            adj[BIN_W+4*i +: 4] = (scr[BIN_W+4*i +: 4] >= 4'd5) ? scr[BIN_W+4*i +: 4] + 4'd3 : scr[BIN_W+4*i +: 4];
    end

    // a digit is blanked only when it and every digit above it are zero; units always shows
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign hi_nz[d] = |bcd[4*DIGITS-1:4*d];
        seg7_digit_encoder u_enc (
            .bcd   (bcd[4*d +: 4]),
            .blank (lz && (d != 0) && !hi_nz[d]),
            .seg   (seg_n[SEG_W*d +: SEG_W])
        );
    end

    always_comb begin
        state_n = (state == IDLE && bus.load) ? SHIFT :
                  (state == SHIFT && cnt == '0) ? DONE :
                  (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            scr     <= '0;
            lz      <= 1'b0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            seg_q   <= '0;
        end else begin
            state   <= state_n;
            valid_q <= state == DONE;
            if (state == IDLE && bus.load) begin
                scr <= {{(4*DIGITS){1'b0}}, cap};
                cnt <= CW'(BIN_W - 1);
                lz  <= bus.blank_lz;
                ovf <= ovf_in;
            end
            if (state == SHIFT) begin
                scr <= adj << 1;
                cnt <= cnt - 1'b1;
            end
            if (state == DONE) begin
                bcd_q <= bcd;
                seg_q <= seg_n;
                ovf_q <= ovf;
            end
        end
    end

    assign bus.busy     = state != IDLE;
    assign bus.valid    = valid_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.seg_out  = seg_q;
endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver: scoreboard bench for the default and a 7-bit/2-digit driver
module tb_score_display_driver;
    typedef struct {
        logic [15:0] bcd;
        logic [27:0] seg;
        logic        ovf;
        int          cyc;
    } exp_t;

    localparam logic [6:0] P [10] = '{
        7'b1110111, 7'b0010010, 7'b1011101, 7'b1011011, 7'b0111010,
        7'b1101011, 7'b1101111, 7'b1010010, 7'b1111111, 7'b1111010
    };

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];

    score_display_driver_if #(.BIN_W(14), .DIGITS(4)) ia ();
    score_display_driver_if #(.BIN_W(7),  .DIGITS(2)) ib ();

    score_display_driver #(.BIN_W(14), .DIGITS(4)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ia));
    score_display_driver #(.BIN_W(7),  .DIGITS(2)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ib));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic exp_t model_b(input int v, input bit lz, input int c);
        exp_t e;
        int s, t, u;
        s = (v > 99) ? 99 : v;
        t = s / 10;
        u = s % 10;
        e.bcd = 16'((t << 4) | u);
        e.seg = {14'b0, (lz && t == 0) ? 7'b0 : P[t], P[u]};
        e.ovf = v > 99;
        e.cyc = c + 9;
        return e;
    endfunction

    task automatic wait_idle_a();
        for (int i = 0; i < 40 && ia.busy; i++) @(negedge Clk);
        if (ia.busy) chk("idle_wait_a", 1, 0);
    endtask

    task automatic pulse_a(input logic [13:0] v, input logic lz);
        ia.value = v;
        ia.blank_lz = lz;
        ia.load = 1'b1;
        @(negedge Clk);
        ia.load = 1'b0;
    endtask

    task automatic run_a(input logic [13:0] v, input logic lz, input logic [15:0] bcd,
                         input logic [27:0] seg, input logic ovf);
        exp_t e;
        wait_idle_a();
        e = '{bcd, seg, ovf, cyc + 16};
        qa.push_back(e);
        pulse_a(v, lz);
        chk("busy_after_load_a", ia.busy, 1);
    endtask

    task automatic run_b(input int v);
        bit lz;
        for (int i = 0; i < 20 && ib.busy; i++) @(negedge Clk);
        if (ib.busy) chk("idle_wait_b", 1, 0);
        lz = (v % 2) == 1;
        qb.push_back(model_b(v, lz, cyc));
        ib.value = 7'(v);
        ib.blank_lz = lz;
        ib.load = 1'b1;
        @(negedge Clk);
        ib.load = 1'b0;
        chk("busy_after_load_b", ib.busy, 1);
    endtask

    always @(negedge Clk) begin : mon_a
        exp_t e;
        if (!Reset && ia.valid) begin
            if (qa.size() == 0) chk("unexpected_valid_a", 1, 0);
            else begin
                e = qa.pop_front();
                chk("bcd_a", ia.bcd_out, e.bcd);
                chk("seg_a", ia.seg_out, e.seg);
                chk("ovf_a", ia.overflow, e.ovf);
                chk("latency_a", cyc, e.cyc);
                chk("busy_at_valid_a", ia.busy, 0);
            end
        end
    end

    always @(negedge Clk) begin : mon_b
        exp_t e;
        if (!Reset && ib.valid) begin
            if (qb.size() == 0) chk("unexpected_valid_b", 1, 0);
            else begin
                e = qb.pop_front();
                chk("bcd_b", ib.bcd_out, e.bcd);
                chk("seg_b", ib.seg_out, e.seg);
                chk("ovf_b", ib.overflow, e.ovf);
                chk("latency_b", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        ia.load = 1'b0; ia.value = '0; ia.blank_lz = 1'b0;
        ib.load = 1'b0; ib.value = '0; ib.blank_lz = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_busy", ia.busy, 0);
        chk("rst_valid", ia.valid, 0);
        chk("rst_ovf", ia.overflow, 0);
        chk("rst_bcd", ia.bcd_out, 0);
        chk("rst_seg", ia.seg_out, 0);
        chk("rst_bcd_b", ib.bcd_out, 0);
        Reset = 1'b0;
        @(negedge Clk);
        run_a(14'd0,     1, 16'h0000, {21'b0, P[0]}, 0);
        run_a(14'd89,    0, 16'h0089, {P[0], P[0], P[8], P[9]}, 0);
        run_a(14'd12000, 0, 16'h9999, {P[9], P[9], P[9], P[9]}, 1);
        run_a(14'd7,     1, 16'h0007, {21'b0, P[7]}, 0);
        run_a(14'd9999,  1, 16'h9999, {P[9], P[9], P[9], P[9]}, 0);
        run_a(14'd10000, 1, 16'h9999, {P[9], P[9], P[9], P[9]}, 1);
        run_a(14'd16383, 0, 16'h9999, {P[9], P[9], P[9], P[9]}, 1);
        run_a(14'd305,   1, 16'h0305, {7'b0, P[3], P[0], P[5]}, 0);
        run_a(14'd1000,  1, 16'h1000, {P[1], P[0], P[0], P[0]}, 0);
        run_a(14'd50,    1, 16'h0050, {14'b0, P[5], P[0]}, 0);
        // 1234 accepted at edge t0; a busy-time request is dropped, the valid-cycle one is taken
        run_a(14'd1234,  0, 16'h1234, {P[1], P[2], P[3], P[4]}, 0);
        t0 = cyc;
        while (cyc != t0 + 2) @(negedge Clk);
        pulse_a(14'd5678, 0);
        while (cyc != t0 + 15) @(negedge Clk);
        chk("busy_in_valid_cycle", ia.busy, 0);
        qa.push_back('{16'h5678, {P[5], P[6], P[7], P[8]}, 1'b0, cyc + 16});
        pulse_a(14'd5678, 0);
        chk("busy_after_valid_cycle_load", ia.busy, 1);
        wait_idle_a();
        t0 = cyc;
        pulse_a(14'd777, 0);
        while (cyc != t0 + 5) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_busy", ia.busy, 0);
        chk("abort_valid", ia.valid, 0);
        chk("abort_bcd", ia.bcd_out, 0);
        chk("abort_seg", ia.seg_out, 0);
        chk("abort_ovf", ia.overflow, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        run_a(14'd42, 1, 16'h0042, {14'b0, P[4], P[2]}, 0);
        for (int v = 0; v < 128; v++) run_b(v);
        for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge Clk);
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);
        repeat (5) @(negedge Clk);
        chk("hold_bcd_a", ia.bcd_out, 16'h0042);
        chk("hold_seg_a", ia.seg_out, {14'b0, P[4], P[2]});
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
- Sequential, parametrised binary-to-segment display driver for the score, combo and streak readouts.
- Converts an unsigned binary value into DIGITS decimal digits using iterative double-dabble, one shift per clock.
- Encodes each digit into the team's 7-bit segment pattern and registers the result for the on-screen digit renderer.
- Adds saturation, optional leading-zero blanking and a load/busy/valid handshake, replacing fixed two-digit table lookups.

Parameters:
- BIN_W, 14, width of the binary input; also the conversion cycle count.
- DIGITS, 4, number of decimal digits produced (1..8).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- value  input  BIN_W  unsigned binary value; sampled on an accepted load.
- load  input  1  start request; accepted only when busy=0.
- blank_lz  input  1  leading-zero blanking enable; sampled with value.
- busy  output  1  high from the cycle after an accepted load until valid has pulsed.
- valid  output  1  one-cycle pulse when bcd_out, seg_out and overflow update.
- overflow  output  1  value exceeded 10^DIGITS-1; result is saturated.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) is in bits [3:0].
- seg_out  output  7*DIGITS  packed segments; digit 0 is in bits [6:0].

Behaviour:
- Single clock domain. Clk and Reset are the only clock and reset. Reset is synchronous and active-high.
- Reset values:
  - busy=0, valid=0, overflow=0.
  - bcd_out=0, seg_out=0.
  - FSM returns to IDLE.
  - Reset during SHIFT or DONE aborts the conversion; no valid pulse follows.
- Segment bit order: [6] top, [5] upper-left, [4] upper-right, [3] middle, [2] lower-left, [1] lower-right, [0] bottom.
- Digit patterns:
  - 0 = 1110111, 1 = 0010010, 2 = 1011101, 3 = 1011011, 4 = 0111010.
  - 5 = 1101011, 6 = 1101111, 7 = 1010010, 8 = 1111111, 9 = 1111010.
  - Codes 10..15 = 0000000.
- FSM state IDLE:
  - busy=0.
  - load=1 captures value into the binary shift register and blank_lz into a flag. BCD scratch is cleared; counter = BIN_W-1; next state SHIFT.
  - If value > 10^DIGITS-1: capture 10^DIGITS-1 instead and set the internal ovf flag.
- FSM state SHIFT:
  - busy=1.
  - Each cycle: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - After exactly BIN_W SHIFT cycles, next state DONE.
- FSM state DONE:
  - busy=1; registers bcd_out, seg_out and overflow; next state IDLE.
  - valid=1 in the cycle after DONE, when the new outputs are first visible. busy=0 in that same cycle.
- Latency: load accepted at edge N -> valid high during cycle N+BIN_W+2. With defaults, a new load is accepted every 16 cycles.
- load while busy=1 is ignored and not queued. load in the valid cycle is accepted (busy=0 there).
- Outputs hold their last result between conversions.
- Leading-zero blanking (flag=1): digits above the most significant non-zero digit give seg=0000000. Digit 0 is never blanked, so a value of 0 shows '0'. bcd_out is never blanked.
- Scratch width is 4*DIGITS+BIN_W. Saturation comparison uses a BIN_W+1-bit constant; if 2^BIN_W-1 <= 10^DIGITS-1, overflow is constant 0.

Decomposition:
- Package display_pkg holds:
  - SEG_W=7.
  - SEG_BLANK.
  - SEG_DIGIT[0:9] pattern constants.
  - State enum {IDLE, SHIFT, DONE}.
  - Function max_decimal(DIGITS).
- Sub-module seg7_digit_encoder: combinational, 4-bit BCD -> 7-bit pattern with a blank input. Instantiated DIGITS times by a generate loop.

Test Plan:
- Reset, then load value=0 with blank_lz=1 -> valid during cycle N+16; bcd_out=0x0000; seg_out={0000000,0000000,0000000,1110111}; overflow=0.
- load value=89 with blank_lz=0 -> bcd_out=0x0089; seg_out={1110111,1110111,1111111,1111010}.
- load value=12000 -> overflow=1; bcd_out=0x9999; every digit = 1111010. Next load of 7 -> overflow=0, seg digit0=1010010, upper digits blanked when blank_lz=1.
- load 1234 then pulse load=5678 at cycles N+3 and N+16 -> first result 0x1234. The N+3 request is ignored. The N+16 request is accepted, producing 0x5678 at cycle N+32.
- Reset at cycle N+5 mid-conversion -> busy=0 next cycle, no valid pulse, outputs zero. A fresh load of 42 then completes normally.
- BIN_W=7, DIGITS=2: sweep 0..127 against a reference model -> 0..99 are exact; 100..127 give 0x99 with overflow=1.
